// File: rtl/load_store_unit.sv
// Load/store unit: CPU word/byte accesses to a single-port word memory, byte stores via read-modify-write.
// Latency: response 1 cycle after accept for errors, 2 for loads/word stores, 3 for byte stores.
// Backpressure: reqReady only in IDLE; one request in flight; response is a pulse with no backpressure.
module load_store_unit #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic        reqByte,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWriteData,
   output logic        rspValid,
   output logic [31:0] rspReadData,
   output logic        rspError,
   output logic        memWriteEnable,
   output logic [31:0] memAdress,
   output logic [31:0] memWriteData,
   input  logic [31:0] memReadData
);

   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          write_q;
   logic          byte_q;
   logic          err_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;

   logic          accept;
   logic          req_err;
   logic [31:0]   merged_word;
   logic [7:0]    lane_byte;

   assign reqReady = (state_q == IDLE) && resetN;
   assign accept   = reqValid && reqReady;

   // Out of range when any address bit above the memory span is set; word accesses must be aligned.
   assign req_err = (|reqAddr[31:AW+2]) || (!reqByte && (reqAddr[1:0] != 2'b00));

   // Next-state selection; byte stores take the READ detour to fetch the word being patched.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_err)                    state_d = RESP;
               else if (reqWrite && !reqByte)  state_d = WRITE;
               else                            state_d = READ;
            end
         end
         READ:    state_d = (write_q && byte_q) ? WRITE : RESP;
         WRITE:   state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // State, request capture at acceptance and read-word capture in READ.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         byte_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            write_q <= reqWrite;
            byte_q  <= reqByte;
            err_q   <= req_err;
            addr_q  <= reqAddr[AW+1:0];
            wdata_q <= reqWriteData;
         end
         if (state_q == READ) begin
            rdata_q <= memReadData;
         end
      end
   end

   // Little-endian lane patch of the fetched word and lane extraction for byte loads.
   always_comb begin
      merged_word = rdata_q;
      lane_byte   = rdata_q[7:0];
      case (addr_q[1:0])
         2'd0: begin merged_word[7:0]   = wdata_q[7:0]; lane_byte = rdata_q[7:0];   end
         2'd1: begin merged_word[15:8]  = wdata_q[7:0]; lane_byte = rdata_q[15:8];  end
         2'd2: begin merged_word[23:16] = wdata_q[7:0]; lane_byte = rdata_q[23:16]; end
         default: begin merged_word[31:24] = wdata_q[7:0]; lane_byte = rdata_q[31:24]; end
      endcase
   end

   assign memAdress      = (state_q != IDLE) ? {{(32-AW){1'b0}}, addr_q[AW+1:2]} : 32'd0;
   assign memWriteEnable = (state_q == WRITE) && resetN;
   assign memWriteData   = (state_q != WRITE) ? 32'd0 : (byte_q ? merged_word : wdata_q);

   assign rspValid = (state_q == RESP);
   assign rspError = (state_q == RESP) && err_q;

   // Load data only for successful loads; stores and errors answer with zero.
   always_comb begin
      rspReadData = 32'd0;
      if ((state_q == RESP) && !err_q && !write_q) begin
         rspReadData = byte_q ? {24'd0, lane_byte} : rdata_q;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, directed vector table, reset and hold sequences.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        resetN;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic        reqByte;
   logic [31:0] reqAddr;
   logic [31:0] reqWriteData;
   logic        rspValid;
   logic [31:0] rspReadData;
   logic        rspError;
   logic        memWriteEnable;
   logic [31:0] memAdress;
   logic [31:0] memWriteData;
   logic [31:0] memReadData;

   logic [31:0] mem [64];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(64)) dut (
      .clk(clk), .resetN(resetN),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqByte(reqByte),
      .reqAddr(reqAddr), .reqWriteData(reqWriteData),
      .rspValid(rspValid), .rspReadData(rspReadData), .rspError(rspError),
      .memWriteEnable(memWriteEnable), .memAdress(memAdress),
      .memWriteData(memWriteData), .memReadData(memReadData)
   );

   assign memReadData = mem[memAdress[5:0]];

   always @(posedge clk) begin
      if (memWriteEnable) mem[memAdress[5:0]] <= memWriteData;
   end

   typedef struct {
      logic        wr;
      logic        by;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic        err;
      logic [31:0] rdata;
      int          nwr;
      logic [31:0] madr;
      logic [31:0] mwd;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat, nwr;
      logic err;
      logic [31:0] rd, madr, mwd;
      @(negedge clk);
      chk($sformatf("v%0d ready", idx), 32'(reqReady), 32'd1);
      reqValid = 1'b1; reqWrite = v.wr; reqByte = v.by; reqAddr = v.addr; reqWriteData = v.wdata;
      @(posedge clk);
      #1 reqValid = 1'b0;
      lat = 0; nwr = 0; err = 1'b0; rd = '0; madr = '0; mwd = '0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (memWriteEnable) begin
            nwr++; madr = memAdress; mwd = memWriteData;
         end
         if (rspValid) begin
            lat = n; err = rspError; rd = rspReadData;
            break;
         end
      end
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d error", idx), 32'(err), 32'(v.err));
      chk($sformatf("v%0d rdata", idx), rd, v.rdata);
      chk($sformatf("v%0d write_count", idx), 32'(nwr), 32'(v.nwr));
      if (v.nwr > 0) begin
         chk($sformatf("v%0d mem_addr", idx), madr, v.madr);
         chk($sformatf("v%0d mem_wdata", idx), mwd, v.mwd);
      end
   endtask

   initial begin
      int rsp_seen;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;

      //            wr    by    addr        wdata         lat err  rdata         nwr madr    mwd
      vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 2, 1'b0, 32'h0,        1, 32'd4,  32'hDEADBEEF};
      vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        2, 1'b0, 32'hDEADBEEF, 0, 32'd0,  32'h0};
      vecs[2]  = '{1'b1, 1'b1, 32'h12,  32'hAAAAAA55, 3, 1'b0, 32'h0,        1, 32'd4,  32'hDE55BEEF};
      vecs[3]  = '{1'b0, 1'b1, 32'h13,  32'h0,        2, 1'b0, 32'h000000DE, 0, 32'd0,  32'h0};
      vecs[4]  = '{1'b0, 1'b1, 32'h10,  32'h0,        2, 1'b0, 32'h000000EF, 0, 32'd0,  32'h0};
      vecs[5]  = '{1'b0, 1'b0, 32'h11,  32'h0,        1, 1'b1, 32'h0,        0, 32'd0,  32'h0};
      vecs[6]  = '{1'b1, 1'b0, 32'h100, 32'h11223344, 1, 1'b1, 32'h0,        0, 32'd0,  32'h0};
      vecs[7]  = '{1'b1, 1'b1, 32'h100, 32'h000000AB, 1, 1'b1, 32'h0,        0, 32'd0,  32'h0};
      vecs[8]  = '{1'b1, 1'b0, 32'hFC,  32'h12345678, 2, 1'b0, 32'h0,        1, 32'd63, 32'h12345678};
      vecs[9]  = '{1'b1, 1'b1, 32'hFF,  32'h0000009A, 3, 1'b0, 32'h0,        1, 32'd63, 32'h9A345678};
      vecs[10] = '{1'b0, 1'b0, 32'hFC,  32'h0,        2, 1'b0, 32'h9A345678, 0, 32'd0,  32'h0};
      vecs[11] = '{1'b0, 1'b1, 32'h11,  32'h0,        2, 1'b0, 32'h000000BE, 0, 32'd0,  32'h0};
      vecs[12] = '{1'b1, 1'b1, 32'h10,  32'hFFFFFF01, 3, 1'b0, 32'h0,        1, 32'd4,  32'hDE55BE01};
      vecs[13] = '{1'b0, 1'b0, 32'h10,  32'h0,        2, 1'b0, 32'hDE55BE01, 0, 32'd0,  32'h0};

      resetN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqByte = 1'b0;
      reqAddr = '0; reqWriteData = '0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("reset ready_low", 32'(reqReady), 32'd0);
      chk("reset wen_low", 32'(memWriteEnable), 32'd0);
      @(posedge clk);
      #1 resetN = 1'b1;
      @(negedge clk);
      chk("idle ready", 32'(reqReady), 32'd1);
      chk("idle rspValid", 32'(rspValid), 32'd0);
      chk("idle rspReadData", rspReadData, 32'd0);
      chk("idle rspError", 32'(rspError), 32'd0);
      chk("idle memWriteEnable", 32'(memWriteEnable), 32'd0);
      chk("idle memAdress", memAdress, 32'd0);
      chk("idle memWriteData", memWriteData, 32'd0);

      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

      // Out-of-range stores must not alias onto word 0.
      chk("mem0 untouched", mem[0], 32'd0);
      chk("mem4 final", mem[4], 32'hDE55BE01);

      // Reset asserted during the WRITE cycle of a byte store.
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqByte = 1'b1; reqAddr = 32'h10; reqWriteData = 32'h77;
      @(posedge clk);
      #1 reqValid = 1'b0;
      @(posedge clk);
      #1 resetN = 1'b0;
      @(negedge clk);
      chk("rstwr memWriteEnable", 32'(memWriteEnable), 32'd0);
      chk("rstwr ready_low", 32'(reqReady), 32'd0);
      @(posedge clk);
      #1 resetN = 1'b1;
      rsp_seen = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (rspValid) rsp_seen++;
      end
      chk("rstwr no_response", 32'(rsp_seen), 32'd0);
      chk("rstwr ready_after", 32'(reqReady), 32'd1);
      chk("rstwr mem4 unchanged", mem[4], 32'hDE55BE01);

      // Request held while busy is taken on the first IDLE edge.
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqByte = 1'b0; reqAddr = 32'h20; reqWriteData = 32'hCAFEF00D;
      @(posedge clk);
      #1 reqWrite = 1'b0; reqWriteData = 32'h0;
      @(negedge clk);
      chk("hold n1 ready", 32'(reqReady), 32'd0);
      chk("hold n1 rspValid", 32'(rspValid), 32'd0);
      @(negedge clk);
      chk("hold n2 rspValid", 32'(rspValid), 32'd1);
      chk("hold n2 ready", 32'(reqReady), 32'd0);
      @(negedge clk);
      chk("hold n3 ready", 32'(reqReady), 32'd1);
      chk("hold n3 rspValid", 32'(rspValid), 32'd0);
      @(posedge clk);
      #1 reqValid = 1'b0;
      @(negedge clk);
      chk("hold n4 rspValid", 32'(rspValid), 32'd0);
      @(negedge clk);
      chk("hold n5 rspValid", 32'(rspValid), 32'd1);
      chk("hold n5 rdata", rspReadData, 32'hCAFEF00D);
      chk("hold mem8", mem[8], 32'hCAFEF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
